fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Controls the operand-forwarding muxes and stall decisions for the 5-stage MIPS pipeline (ID, EX, MEM1, MEM2, WB).
- Keeps a registered scoreboard of the destination register and result class for the instructions in EX, MEM1, MEM2 and WB.
- Picks, for each ID-stage source operand, the youngest in-flight producer whose data is already available.
- Stalls ID when the youngest matching producer is not ready yet, or when the multi-cycle divider is busy.

Parameters:
DIV_CYCLES, 32, number of cycles div_busy stays high after a divide issues (must be >= 1)
CNT_W, 6, width of the divider countdown counter (must satisfy 2^CNT_W > DIV_CYCLES)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high (already decided)
id_valid  in  1  ID slot holds a real instruction
id_rs  in  5  rs field of the ID instruction
id_rt  in  5  rt field of the ID instruction
id_rs_used  in  1  ID instruction reads rs
id_rt_used  in  1  ID instruction reads rt
id_waddr  in  5  destination GPR; 0 means no write
id_wclass  in  2  result class: 00 ALU, 01 MUL/HILO, 10 LOAD, 11 CP0/SC
id_hilo_rd  in  1  ID instruction reads HI/LO (mfhi/mflo)
id_div  in  1  ID instruction is div/divu
ext_stall  in  1  global freeze from cache/bus; all stages hold
flush  in  1  exception/eret; kill ID, EX and MEM1
rs_sel  out  3  rs source: 000 GPR, 001 EX, 010 MEM1, 011 MEM2, 100 WB
rt_sel  out  3  rt source; same encoding as rs_sel
id_stall  out  1  hold PC/IF/ID and inject a bubble into EX
div_busy  out  1  divider is running

Behaviour:
Scoreboard entries (EX, MEM1, MEM2, WB): each holds {v, waddr, wclass}. Reset clears all v to 0. Output reset values: div_busy=0, counter=0. Combinational outputs after reset: rs_sel=rt_sel=000, id_stall=0.

Advance rule, applied when ext_stall=0 and flush=0:
- WB<=MEM2, MEM2<=MEM1, MEM1<=EX.
- EX<=ID entry if id_valid && !id_stall && id_waddr!=0; otherwise EX<=bubble (v=0).

Other advance cases:
- ext_stall=1, flush=0: all four entries hold.
- flush=1, ext_stall=0: EX<=bubble, MEM1<=bubble, WB<=MEM2, MEM2<=bubble.
- flush=1, ext_stall=1: flush wins for EX and MEM1 (cleared); MEM2 and WB hold.

Match rule: a stage matches operand X if v=1, waddr==X, X!=0, and X is used. Register 0 never matches, so its sel is 000 and it never stalls.

Operand selection:
- Find the youngest matching stage, checking EX, then MEM1, then MEM2, then WB. With no match, sel=000.
- Readiness of the match:
  - EX: ready only for class 00; sel=001.
  - MEM1: ready for class 00 or 01; sel=010.
  - MEM2: ready for any class; sel=011.
  - WB: ready for any class; sel=100.
- If the youngest match is not ready: hazard=1 and that operand's sel=000. Older matches are never used in this case.
- Hazards are evaluated only when id_valid=1.

Stall: id_stall = id_valid && (hazard_rs || hazard_rt || ((id_hilo_rd || id_div) && div_busy)). id_stall does not depend on ext_stall.

Divider:
- Issue: the cycle with id_valid && id_div && !id_stall && !ext_stall && !flush.
- On issue: div_busy<=1 and counter<=DIV_CYCLES-1.
- While busy, counter decrements every cycle, including during ext_stall.
- In a busy cycle with counter==0: div_busy<=0. div_busy is therefore high for exactly DIV_CYCLES cycles.
- flush: div_busy<=0 and counter<=0 (divide aborted).
- rst: divider returns to idle.

Latency: sel and id_stall are combinational from the ID inputs plus registered state. Load-use with distance 1 gives 2 stall cycles; MUL-use with distance 1 gives 1 stall cycle.

Decomposition:
Shared package: the wclass codes (WCLS_ALU/MUL/LOAD/CP0), the sel codes (SEL_GPR/EX/MEM1/MEM2/WB) and the scoreboard entry struct.
One sub-module, fwd_pick: purely combinational, one instance per operand (rs, rt). Takes the operand number, its used bit and the 4 entries; returns sel and hazard.

Test Plan:
- addu $3,$1,$2 then subu $4,$3,$5 -> rs_sel=001, id_stall=0.
- lw $2 then addu $6,$2,$2 -> id_stall=1 for 2 cycles, then rs_sel=rt_sel=011; EX shows 2 bubbles.
- Producers of $7 in EX (class 10) and MEM2 (class 00), consumer reads $7 -> stall (youngest not ready); rs_sel=000, never 011 from the older producer.
- div with DIV_CYCLES=4, then mfhi -> div_busy high exactly 4 cycles; id_stall high for those 4 cycles; mfhi accepted the cycle div_busy falls.
- Load in EX plus ext_stall=1 for 3 cycles -> scoreboard frozen; stall persists; after release, same 2-cycle load-use behaviour.
- flush with ALU producers in EX and MEM1 and one load in MEM2 -> next cycle EX.v=MEM1.v=MEM2.v=0, WB holds the load; a reader of any register whose only in-flight producer was in EX or MEM1 gets sel=000 with no stall. Separately, flush while div_busy=1 -> div_busy=0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard controller of the 5-stage pipeline.
// Holds the result-class codes, the forwarding-mux select codes, the per-stage
// scoreboard entry and the operand/producer match helper.
package fwd_hazard_ctrl_pkg;

    // Result class: decides the first stage where a producer's value can be forwarded
    localparam logic [1:0] WCLS_ALU  = 2'b00;
    localparam logic [1:0] WCLS_MUL  = 2'b01;
    localparam logic [1:0] WCLS_LOAD = 2'b10;
    localparam logic [1:0] WCLS_CP0  = 2'b11;

    // Operand mux select codes
    localparam logic [2:0] SEL_GPR  = 3'b000;
    localparam logic [2:0] SEL_EX   = 3'b001;
    localparam logic [2:0] SEL_MEM1 = 3'b010;
    localparam logic [2:0] SEL_MEM2 = 3'b011;
    localparam logic [2:0] SEL_WB   = 3'b100;

    typedef struct packed {
        logic       v;
        logic [4:0] waddr;
        logic [1:0] wclass;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{v: 1'b0, waddr: 5'd0, wclass: WCLS_ALU};

    // $0 is hard-wired, so it can never be produced by an in-flight instruction
    function automatic logic sb_match(sb_entry_t e, logic [4:0] op, logic used);
        return e.v && used && (op != 5'd0) && (e.waddr == op);
    endfunction

endpackage

// File: rtl/fwd_pick.sv
// Forwarding picker for one ID-stage source operand.
// Ports:
//   op     in   source register number
//   used   in   the ID instruction actually reads this operand
//   ex, mem1, mem2, wb  in  scoreboard entries, youngest first
//   sel    out  forwarding mux select (SEL_* codes)
//   hazard out  youngest matching producer cannot supply its value yet
// Purely combinational. Only the youngest match is considered: an older producer
// must never be forwarded over a younger, not-yet-ready one.
module fwd_pick
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [4:0] op,
    input  logic       used,
    input  sb_entry_t  ex,
    input  sb_entry_t  mem1,
    input  sb_entry_t  mem2,
    input  sb_entry_t  wb,
    output logic [2:0] sel,
    output logic       hazard
);

    // Every class is ready by MEM2, so those result classes are never inspected
    logic unused_cls;
    assign unused_cls = ^{mem2.wclass, wb.wclass};

    always_comb begin
        sel    = SEL_GPR;
        hazard = 1'b0;
        if (sb_match(ex, op, used)) begin
            if (ex.wclass == WCLS_ALU) begin
                sel = SEL_EX;
            end else begin
                hazard = 1'b1;
            end
        end else if (sb_match(mem1, op, used)) begin
            if ((mem1.wclass == WCLS_ALU) || (mem1.wclass == WCLS_MUL)) begin
                sel = SEL_MEM1;
            end else begin
                hazard = 1'b1;
            end
        end else if (sb_match(mem2, op, used)) begin
            sel = SEL_MEM2;
        end else if (sb_match(wb, op, used)) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and stall control for the ID/EX/MEM1/MEM2/WB pipeline.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   id_*              decoded fields of the instruction sitting in ID
//   ext_stall         global freeze from cache/bus
//   flush             exception/eret; kills ID, EX and MEM1 and aborts a divide
//   rs_sel, rt_sel    forwarding mux selects for the ID operands
//   id_stall          hold PC/IF/ID and send a bubble into EX
//   div_busy          multi-cycle divider is running
// The scoreboard mirrors destination/class of EX..WB so hazards can be resolved
// from ID fields alone.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] id_waddr,
    input  logic [1:0] id_wclass,
    input  logic       id_hilo_rd,
    input  logic       id_div,
    input  logic       ext_stall,
    input  logic       flush,
    output logic [2:0] rs_sel,
    output logic [2:0] rt_sel,
    output logic       id_stall,
    output logic       div_busy
);

    sb_entry_t ex_q, mem1_q, mem2_q, wb_q;
    sb_entry_t ex_d, mem1_d, mem2_d, wb_d;
    sb_entry_t id_entry;

    logic             pick_rs_hazard, pick_rt_hazard;
    logic             div_busy_q, div_busy_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             div_issue;

    fwd_pick u_pick_rs (
        .op     (id_rs),
        .used   (id_rs_used),
        .ex     (ex_q),
        .mem1   (mem1_q),
        .mem2   (mem2_q),
        .wb     (wb_q),
        .sel    (rs_sel),
        .hazard (pick_rs_hazard)
    );

    fwd_pick u_pick_rt (
        .op     (id_rt),
        .used   (id_rt_used),
        .ex     (ex_q),
        .mem1   (mem1_q),
        .mem2   (mem2_q),
        .wb     (wb_q),
        .sel    (rt_sel),
        .hazard (pick_rt_hazard)
    );

    // Deliberately independent of ext_stall: the freeze already holds ID
    assign id_stall = id_valid &&
                      (pick_rs_hazard || pick_rt_hazard ||
                       ((id_hilo_rd || id_div) && div_busy_q));

    assign div_busy  = div_busy_q;
    assign div_issue = id_valid && id_div && !id_stall && !ext_stall && !flush;

    // Instructions without a GPR destination never enter the scoreboard
    always_comb begin
        id_entry        = SB_BUBBLE;
        id_entry.v      = id_valid && !id_stall && (id_waddr != 5'd0);
        id_entry.waddr  = id_waddr;
        id_entry.wclass = id_wclass;
    end

    always_comb begin
        ex_d   = ex_q;
        mem1_d = mem1_q;
        mem2_d = mem2_q;
        wb_d   = wb_q;
        if (flush) begin
            // Flush kills the young stages even under a freeze; MEM2/WB only move if unfrozen
            ex_d   = SB_BUBBLE;
            mem1_d = SB_BUBBLE;
            if (!ext_stall) begin
                mem2_d = SB_BUBBLE;
                wb_d   = mem2_q;
            end
        end else if (!ext_stall) begin
            ex_d   = id_entry;
            mem1_d = ex_q;
            mem2_d = mem1_q;
            wb_d   = mem2_q;
        end
    end

    // Countdown keeps running through ext_stall: the divider is not frozen by the bus
    always_comb begin
        div_busy_d = div_busy_q;
        div_cnt_d  = div_cnt_q;
        if (flush) begin
            div_busy_d = 1'b0;
            div_cnt_d  = '0;
        end else if (div_issue) begin
            div_busy_d = 1'b1;
            div_cnt_d  = CNT_W'(DIV_CYCLES - 1);
        end else if (div_busy_q) begin
            if (div_cnt_q == '0) begin
                div_busy_d = 1'b0;
            end else begin
                div_cnt_d = div_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= SB_BUBBLE;
            mem1_q     <= SB_BUBBLE;
            mem2_q     <= SB_BUBBLE;
            wb_q       <= SB_BUBBLE;
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
        end else begin
            ex_q       <= ex_d;
            mem1_q     <= mem1_d;
            mem2_q     <= mem2_d;
            wb_q       <= wb_d;
            div_busy_q <= div_busy_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl (DIV_CYCLES=4). Each scenario is a table
// of per-cycle ID stimulus with hand-derived expected outputs; the expectation is
// queued when the row is driven and popped when the outputs are sampled.
module tb_fwd_hazard_ctrl;

    localparam int ALU = 0;
    localparam int MUL = 1;
    localparam int LD  = 2;
    localparam int CP0 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt;
    logic       id_rs_used, id_rt_used;
    logic [4:0] id_waddr;
    logic [1:0] id_wclass;
    logic       id_hilo_rd, id_div;
    logic       ext_stall, flush;
    logic [2:0] rs_sel, rt_sel;
    logic       id_stall, div_busy;

    typedef struct packed {
        logic [2:0] rs_sel;
        logic [2:0] rt_sel;
        logic       stall;
        logic       busy;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic [4:0] waddr;
        logic [1:0] wcls;
        logic       hilo;
        logic       div;
        logic       ext;
        logic       fl;
        obs_t       exp;
    } row_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fwd_hazard_ctrl #(
        .DIV_CYCLES (4),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_waddr   (id_waddr),
        .id_wclass  (id_wclass),
        .id_hilo_rd (id_hilo_rd),
        .id_div     (id_div),
        .ext_stall  (ext_stall),
        .flush      (flush),
        .rs_sel     (rs_sel),
        .rt_sel     (rt_sel),
        .id_stall   (id_stall),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    // Columns: rst valid rs rt rs_used rt_used waddr wclass hilo div ext flush |
    //          exp_rs_sel exp_rt_sel exp_stall exp_busy
    function automatic row_t mk(int r, int v, int rs, int rt, int rsu, int rtu, int wa,
                                int wc, int hilo, int dv, int ext, int fl,
                                int ers, int ert, int est, int eb);
        row_t m;
        m.rst   = r[0];
        m.valid = v[0];
        m.rs    = rs[4:0];
        m.rt    = rt[4:0];
        m.rsu   = rsu[0];
        m.rtu   = rtu[0];
        m.waddr = wa[4:0];
        m.wcls  = wc[1:0];
        m.hilo  = hilo[0];
        m.div   = dv[0];
        m.ext   = ext[0];
        m.fl    = fl[0];
        m.exp.rs_sel = ers[2:0];
        m.exp.rt_sel = ert[2:0];
        m.exp.stall  = est[0];
        m.exp.busy   = eb[0];
        return m;
    endfunction

    task automatic apply(input row_t r);
        rst        = r.rst;
        id_valid   = r.valid;
        id_rs      = r.rs;
        id_rt      = r.rt;
        id_rs_used = r.rsu;
        id_rt_used = r.rtu;
        id_waddr   = r.waddr;
        id_wclass  = r.wcls;
        id_hilo_rd = r.hilo;
        id_div     = r.div;
        ext_stall  = r.ext;
        flush      = r.fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        apply(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (5) tick();
    endtask

    task automatic test_reset();
        row_t t[$];
        obs_t got, exp;
        rst = 1'b1;
        apply(mk(1, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) tick();
        t.push_back(mk(0, 1, 3, 4, 1, 1, 5, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 5, 0, 1, 1, 0, ALU, 0, 0, 0, 0, 1, 0, 0, 0));
        t.push_back(mk(1, 1, 5, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 2, 0, 0, 0));
        t.push_back(mk(0, 1, 5, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_alu_fwd();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 1, 2, 1, 1, 3, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 3, 5, 1, 1, 4, ALU, 0, 0, 0, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 1, 3, 4, 1, 1, 0, ALU, 0, 0, 0, 0, 2, 1, 0, 0));
        t.push_back(mk(0, 1, 4, 3, 1, 1, 0, LD,  0, 0, 0, 0, 2, 3, 0, 0));
        t.push_back(mk(0, 1, 3, 4, 1, 1, 0, ALU, 0, 0, 0, 0, 4, 3, 0, 0));
        t.push_back(mk(0, 1, 3, 4, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL alu_fwd[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 1, 0, 1, 0, 2, LD,  0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 2, 2, 1, 1, 6, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 2, 2, 1, 1, 6, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 2, 2, 1, 1, 6, ALU, 0, 0, 0, 0, 3, 3, 0, 0));
        t.push_back(mk(0, 1, 6, 2, 1, 1, 0, ALU, 0, 0, 0, 0, 1, 4, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_youngest();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 7, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 7, LD,  0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 7, 7, 1, 1, 8, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 7, 7, 1, 1, 8, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 7, 7, 1, 1, 8, ALU, 0, 0, 0, 0, 3, 3, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL youngest[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_mul_cp0();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 9,  MUL, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 9, 0, 1, 0, 0,  ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 9, 0, 1, 0, 0,  ALU, 0, 0, 0, 0, 2, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 10, CP0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 10, 0, 1, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 0, 10, 0, 1, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 0, 10, 0, 1, 0, ALU, 0, 0, 0, 0, 0, 3, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mul_cp0[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_ext_stall();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 1, 0, 1, 0, 2, LD,  0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 2, 0, 1, 0, 6, ALU, 0, 0, 1, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 0, 2, 0, 1, 0, 6, ALU, 0, 0, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 2, 0, 1, 0, 6, ALU, 0, 0, 1, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 2, 0, 1, 0, 6, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 2, 0, 1, 0, 6, ALU, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(mk(0, 1, 2, 0, 1, 0, 6, ALU, 0, 0, 0, 0, 3, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ext_stall[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_div();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 1, 2, 1, 1, 0, ALU, 0, 1, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 3, MUL, 1, 0, 0, 0, 0, 0, 1, 1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 1, 1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 3, MUL, 1, 0, 0, 0, 0, 0, 1, 1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 3, MUL, 1, 0, 0, 0, 0, 0, 1, 1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 3, MUL, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 0, 0, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 0, 0, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 0, 0, 0, 1));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, ALU, 0, 1, 1, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL div[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 11, LD,  0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 12, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 13, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 20, ALU, 0, 0, 0, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 12, 11, 1, 1, 0, ALU, 0, 0, 0, 0, 0, 4, 0, 0));
        t.push_back(mk(0, 1, 13, 20, 1, 1, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 14, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 15, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 16, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 1, 1, 0, 0, 0, 0));
        t.push_back(mk(0, 1, 14, 15, 1, 1, 0, ALU, 0, 0, 0, 0, 3, 0, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0,  ALU, 0, 1, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 0, 0, 0, 0, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 0, 1, 0, 0, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0,  ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        row_t t[$];
        obs_t got, exp;
        drain();
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 0, 0));
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb_q.push_back(t[i].exp);
            @(negedge clk);
            got = {rs_sel, rt_sel, id_stall, div_busy};
            exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_abort[%0d]: got rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b, expected rs_sel=%0d rt_sel=%0d id_stall=%0b div_busy=%0b",
                         i, got.rs_sel, got.rt_sel, got.stall, got.busy,
                         exp.rs_sel, exp.rt_sel, exp.stall, exp.busy);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_mul_cp0();
        test_ext_stall();
        test_div();
        test_flush();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
